// File: rtl/imm_pkg.sv
// Decode-stage shared definitions: RV32I/RV64I opcode map and immediate format codes.
// No state, no latency, no handshake.
package imm_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   // Packed width of imm_res_t {imm, fmt, target, illegal} for a given XLEN.
   function automatic int res_width(input int xlen);
      return 2 * xlen + 4;
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: {inst, pc} -> {imm, fmt, target, illegal}.
// Zero latency; no handshake, the owner registers the result.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]                inst,
   input  logic [XLEN-1:0]            pc,
   output logic [res_width(XLEN)-1:0] res
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic [XLEN-1:0] target;
      logic            illegal;
   } imm_res_t;

   imm_res_t           r;
   logic signed [31:0] imm32;
   logic               pcrel;

   always_comb begin
      r     = '0;
      imm32 = '0;
      pcrel = 1'b0;
      case (inst[6:0])
         OP_LOAD, OP_IMM, OP_JALR: begin
            r.fmt = FMT_I;
            imm32 = {{20{inst[31]}}, inst[31:20]};
         end
         OP_STORE: begin
            r.fmt = FMT_S;
            imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         OP_BRANCH: begin
            r.fmt = FMT_B;
            imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            pcrel = 1'b1;
         end
         OP_LUI: begin
            r.fmt = FMT_U;
            imm32 = {inst[31:12], 12'b0};
         end
         OP_AUIPC: begin
            r.fmt = FMT_U;
            imm32 = {inst[31:12], 12'b0};
            pcrel = 1'b1;
         end
         OP_JAL: begin
            r.fmt = FMT_J;
            imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            pcrel = 1'b1;
         end
         OP_REG:  r.fmt = FMT_R;
         default: r.illegal = 1'b1;
      endcase
      // Signed cast replicates inst[31] up to XLEN-1 on RV64.
      r.imm    = XLEN'(imm32);
      r.target = pc + (pcrel ? r.imm : XLEN'(4));
   end

   assign res = r;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator between fetch and register-read/execute.
// Latency 1 cycle from input transfer; 1/cycle throughput with out_ready high.
// Backpressure: SKID=1 absorbs one extra instruction with registered in_ready; SKID=0 stalls combinationally.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   typedef struct packed {
      logic [XLEN-1:0] imm;
      fmt_e            fmt;
      logic [XLEN-1:0] target;
      logic            illegal;
   } imm_res_t;

   imm_res_t dec;
   imm_res_t out_q;
   imm_res_t skid_q;
   logic     out_valid_q;
   logic     skid_valid;
   logic     in_fire;
   logic     out_free;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst (in_inst),
      .pc   (in_pc),
      .res  (dec)
   );

   // With the skid entry, readiness depends only on state, never on out_ready.
   assign in_ready = !flush && ((SKID != 0) ? !skid_valid : (!out_valid_q || out_ready));
   assign in_fire  = in_valid && in_ready;
   assign out_free = !out_valid_q || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            out_q       <= skid_q;
            out_valid_q <= 1'b1;
            skid_valid  <= 1'b0;
         end else begin
            out_valid_q <= in_fire;
            if (in_fire) out_q <= dec;
         end
      end else if ((SKID != 0) && in_fire) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_target  = out_q.target;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN32/SKID1, XLEN32/SKID0, XLEN64/SKID1) on shared stimulus,
// directed format/stall/flush/reset scenarios plus a randomized run against an occupancy-queue reference model.
module tb_imm_gen_pipe;

   logic        clk, rst_n, flush, in_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;

   logic        s32_ir, s32_ov, s32_ill, n32_ir, n32_ov, n32_ill, s64_ir, s64_ov, s64_ill;
   logic [31:0] s32_imm, s32_tgt, n32_imm, n32_tgt;
   logic [63:0] s64_imm, s64_tgt;
   logic [2:0]  s32_fmt, n32_fmt, s64_fmt;

   imm_gen_pipe #(.XLEN(32), .SKID(1)) dut_s32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s32_ir),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(s32_ov), .out_ready(out_ready),
      .out_imm(s32_imm), .out_fmt(s32_fmt), .out_target(s32_tgt), .out_illegal(s32_ill));

   imm_gen_pipe #(.XLEN(32), .SKID(0)) dut_n32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(n32_ir),
      .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(n32_ov), .out_ready(out_ready),
      .out_imm(n32_imm), .out_fmt(n32_fmt), .out_target(n32_tgt), .out_illegal(n32_ill));

   imm_gen_pipe #(.XLEN(64), .SKID(1)) dut_s64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s64_ir),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(s64_ov), .out_ready(out_ready),
      .out_imm(s64_imm), .out_fmt(s64_fmt), .out_target(s64_tgt), .out_illegal(s64_ill));

   logic        ov[3], ir[3], oill[3];
   logic [63:0] oimm[3], otgt[3];
   logic [2:0]  ofmt[3];

   assign ov[0] = s32_ov;  assign ir[0] = s32_ir;  assign oill[0] = s32_ill;
   assign ov[1] = n32_ov;  assign ir[1] = n32_ir;  assign oill[1] = n32_ill;
   assign ov[2] = s64_ov;  assign ir[2] = s64_ir;  assign oill[2] = s64_ill;
   assign oimm[0] = {32'h0, s32_imm}; assign otgt[0] = {32'h0, s32_tgt}; assign ofmt[0] = s32_fmt;
   assign oimm[1] = {32'h0, n32_imm}; assign otgt[1] = {32'h0, n32_tgt}; assign ofmt[1] = n32_fmt;
   assign oimm[2] = s64_imm;          assign otgt[2] = s64_tgt;          assign ofmt[2] = s64_fmt;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [63:0] tgt;
      logic        ill;
   } exp_t;

   exp_t mq[3][4];
   int   hd[3], cnt[3];
   int   tests = 0, fails = 0;
   bit   sb_en = 0;
   exp_t sb_e;
   logic sb_rdy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode from the instruction-set field definitions, using signed integer arithmetic.
   function automatic exp_t ref_dec(input logic [31:0] inst, input logic [63:0] pc, input int xlen);
      exp_t    r;
      longint  imm;
      longint unsigned mask;
      bit      pcrel;
      r   = '0;
      imm = 0;
      case (inst[6:0])
         7'h03, 7'h13, 7'h67: begin
            r.fmt = 3'd1;
            imm = longint'(inst[31:20]) - (inst[31] ? 4096 : 0);
         end
         7'h23: begin
            r.fmt = 3'd2;
            imm = longint'(inst[31:25]) * 32 + longint'(inst[11:7]) - (inst[31] ? 4096 : 0);
         end
         7'h63: begin
            r.fmt = 3'd3;
            imm = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2
                  - (inst[31] ? 4096 : 0);
         end
         7'h37, 7'h17: begin
            r.fmt = 3'd4;
            imm = longint'(inst[31:12]) * 4096 - (inst[31] ? 64'sh1_0000_0000 : 64'sh0);
         end
         7'h6F: begin
            r.fmt = 3'd5;
            imm = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2
                  - (inst[31] ? 1048576 : 0);
         end
         7'h33:   r.fmt = 3'd0;
         default: r.ill = 1'b1;
      endcase
      pcrel = (inst[6:0] == 7'h63) || (inst[6:0] == 7'h6F) || (inst[6:0] == 7'h17);
      mask  = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      r.imm = 64'(imm) & mask;
      r.tgt = ((pc & mask) + (pcrel ? 64'(imm) : 64'd4)) & mask;
      return r;
   endfunction

   // Scoreboard: each instance holds exactly the accepted-but-not-delivered instructions, in order.
   always @(negedge clk) begin
      if (!rst_n || !sb_en) begin
         for (int d = 0; d < 3; d++) begin
            cnt[d] = 0;
            hd[d]  = 0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            sb_rdy = flush ? 1'b0 : ((d == 1) ? (cnt[d] == 0 || out_ready) : (cnt[d] < 2));
            tests++;
            if (ir[d] !== sb_rdy) begin
               fails++;
               $display("FAIL sb_in_ready dut%0d t=%0t: got %b want %b", d, $time, ir[d], sb_rdy);
            end
            tests++;
            if (ov[d] !== (cnt[d] != 0)) begin
               fails++;
               $display("FAIL sb_out_valid dut%0d t=%0t: got %b want %b", d, $time, ov[d], cnt[d] != 0);
            end
            if (cnt[d] != 0) begin
               sb_e = mq[d][hd[d]];
               tests++;
               if ({oimm[d], ofmt[d], otgt[d], oill[d]} !== sb_e) begin
                  fails++;
                  $display("FAIL sb_data dut%0d t=%0t: got imm=%h fmt=%0d tgt=%h ill=%b want imm=%h fmt=%0d tgt=%h ill=%b",
                           d, $time, oimm[d], ofmt[d], otgt[d], oill[d], sb_e.imm, sb_e.fmt, sb_e.tgt, sb_e.ill);
               end
            end
            if (flush) begin
               cnt[d] = 0;
            end else begin
               if (cnt[d] != 0 && out_ready) begin
                  hd[d]  = (hd[d] + 1) % 4;
                  cnt[d] = cnt[d] - 1;
               end
               if (in_valid && sb_rdy) begin
                  mq[d][(hd[d] + cnt[d]) % 4] = ref_dec(in_inst, in_pc, (d == 2) ? 64 : 32);
                  cnt[d] = cnt[d] + 1;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send1(input logic [31:0] inst, input logic [63:0] pc);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = pc;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if ({s32_ov, n32_ov, s64_ov} !== 3'b000) begin
         fails++; $display("FAIL reset_out_valid: got %b want 000", {s32_ov, n32_ov, s64_ov});
      end
      tests++;
      if ({s32_ir, n32_ir, s64_ir} !== 3'b111) begin
         fails++; $display("FAIL reset_in_ready: got %b want 111", {s32_ir, n32_ir, s64_ir});
      end
      tests++;
      if ({s32_imm, s32_tgt, s32_fmt, s32_ill, s64_imm, s64_tgt, s64_fmt, s64_ill} !== '0) begin
         fails++; $display("FAIL reset_data: got imm=%h tgt=%h imm64=%h tgt64=%h", s32_imm, s32_tgt, s64_imm, s64_tgt);
      end
      cyc();
      cyc();
      rst_n = 1'b1;
      sb_en = 1'b1;
      #1;
      tests++;
      if ({s32_ir, n32_ir, s64_ir} !== 3'b111) begin
         fails++; $display("FAIL post_reset_in_ready: got %b want 111", {s32_ir, n32_ir, s64_ir});
      end
   endtask

   task automatic test_formats();
      out_ready = 1'b1;
      send1(32'hFFF0_0093, 64'h1000);
      tests++;
      if ({s32_ov, s32_imm, s32_fmt, s32_tgt} !== {1'b1, 32'hFFFF_FFFF, 3'd1, 32'h1004}) begin
         fails++; $display("FAIL addi: got v=%b imm=%h fmt=%0d tgt=%h want v=1 imm=ffffffff fmt=1 tgt=00001004", s32_ov, s32_imm, s32_fmt, s32_tgt);
      end
      tests++;
      if (s64_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         fails++; $display("FAIL addi64: got imm=%h want ffffffffffffffff", s64_imm);
      end
      send1(32'hFE00_0EE3, 64'h100);
      tests++;
      if ({s32_imm, s32_fmt, s32_tgt} !== {32'hFFFF_FFFC, 3'd3, 32'h0000_00FC}) begin
         fails++; $display("FAIL beq: got imm=%h fmt=%0d tgt=%h want imm=fffffffc fmt=3 tgt=000000fc", s32_imm, s32_fmt, s32_tgt);
      end
      tests++;
      if (s64_tgt !== 64'hFC) begin
         fails++; $display("FAIL beq64_tgt: got %h want 00000000000000fc", s64_tgt);
      end
      send1(32'h0010_00EF, 64'hFFFF_FFFF_FFFF_F800);
      tests++;
      if ({s32_imm, s32_fmt, s32_tgt} !== {32'h800, 3'd5, 32'h0}) begin
         fails++; $display("FAIL jal_wrap: got imm=%h fmt=%0d tgt=%h want imm=00000800 fmt=5 tgt=00000000", s32_imm, s32_fmt, s32_tgt);
      end
      tests++;
      if (s64_tgt !== 64'h0) begin
         fails++; $display("FAIL jal_wrap64: got tgt=%h want 0", s64_tgt);
      end
      send1(32'h1234_50B7, 64'h2000);
      tests++;
      if ({s32_imm, s32_fmt, s32_tgt} !== {32'h1234_5000, 3'd4, 32'h2004}) begin
         fails++; $display("FAIL lui: got imm=%h fmt=%0d tgt=%h want imm=12345000 fmt=4 tgt=00002004", s32_imm, s32_fmt, s32_tgt);
      end
      send1(32'h8000_00B7, 64'h0);
      tests++;
      if (s64_imm !== 64'hFFFF_FFFF_8000_0000 || s32_imm !== 32'h8000_0000) begin
         fails++; $display("FAIL lui_sext: got imm64=%h imm32=%h want ffffffff80000000/80000000", s64_imm, s32_imm);
      end
      send1(32'h0000_007F, 64'h40);
      tests++;
      if ({s32_ill, s32_imm, s32_fmt, s64_ill, s64_imm} !== {1'b1, 32'h0, 3'd0, 1'b1, 64'h0}) begin
         fails++; $display("FAIL illegal: got ill=%b imm=%h fmt=%0d ill64=%b imm64=%h want 1/0/0/1/0", s32_ill, s32_imm, s32_fmt, s64_ill, s64_imm);
      end
      cyc();
   endtask

   task automatic test_skid_stall();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pc     = 64'h400;
      in_inst   = 32'h0010_0013;
      cyc();
      in_inst = 32'h0020_0013;
      tests++;
      if ({s32_ir, n32_ir, s32_imm} !== {1'b1, 1'b0, 32'd1}) begin
         fails++; $display("FAIL stall_a: got ir_s=%b ir_n=%b imm=%h want 1/0/00000001", s32_ir, n32_ir, s32_imm);
      end
      cyc();
      in_inst = 32'h0030_0013;
      tests++;
      if ({s32_ir, s32_ov, s32_imm} !== {1'b0, 1'b1, 32'd1}) begin
         fails++; $display("FAIL stall_skid_full: got ir=%b v=%b imm=%h want 0/1/00000001", s32_ir, s32_ov, s32_imm);
      end
      cyc();
      out_ready = 1'b1;
      #1;
      tests++;
      if ({s32_ir, n32_ir, s32_imm, n32_imm} !== {1'b0, 1'b1, 32'd1, 32'd1}) begin
         fails++; $display("FAIL stall_hold: got ir_s=%b ir_n=%b imm_s=%h imm_n=%h want 0/1/1/1", s32_ir, n32_ir, s32_imm, n32_imm);
      end
      cyc();
      tests++;
      if ({s32_ov, s32_imm, s32_ir, n32_imm} !== {1'b1, 32'd2, 1'b1, 32'd3}) begin
         fails++; $display("FAIL drain_b: got v=%b imm_s=%h ir_s=%b imm_n=%h want 1/2/1/3", s32_ov, s32_imm, s32_ir, n32_imm);
      end
      cyc();
      in_valid = 1'b0;
      tests++;
      if ({s32_ov, s32_imm} !== {1'b1, 32'd3}) begin
         fails++; $display("FAIL drain_c: got v=%b imm=%h want 1/00000003", s32_ov, s32_imm);
      end
      cyc();
      tests++;
      if ({s32_ov, n32_ov, s64_ov} !== 3'b000) begin
         fails++; $display("FAIL drain_empty: got %b want 000", {s32_ov, n32_ov, s64_ov});
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'h0050_0013;
      cyc();
      in_inst = 32'h0060_0013;
      cyc();
      flush   = 1'b1;
      in_inst = 32'h0070_0013;
      #1;
      tests++;
      if ({s32_ir, n32_ir, s64_ir} !== 3'b000) begin
         fails++; $display("FAIL flush_in_ready: got %b want 000", {s32_ir, n32_ir, s64_ir});
      end
      cyc();
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      tests++;
      if ({s32_ov, n32_ov, s64_ov, s32_ir, n32_ir, s64_ir} !== 6'b000_111) begin
         fails++; $display("FAIL flush_clear: got v=%b ir=%b want 000/111", {s32_ov, n32_ov, s64_ov}, {s32_ir, n32_ir, s64_ir});
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_inst   = 32'hFFF0_0093;
      in_pc     = 64'h8000;
      cyc();
      in_inst = 32'h0010_00EF;
      cyc();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      tests++;
      if ({s32_ov, s32_imm, s32_tgt, s32_fmt, s32_ill, s32_ir} !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1}) begin
         fails++; $display("FAIL reset_mid: got v=%b imm=%h tgt=%h fmt=%0d ill=%b ir=%b", s32_ov, s32_imm, s32_tgt, s32_fmt, s32_ill, s32_ir);
      end
      tests++;
      if ({s64_ov, s64_imm, s64_tgt, n32_ov, n32_ir} !== {1'b0, 64'h0, 64'h0, 1'b0, 1'b1}) begin
         fails++; $display("FAIL reset_mid_other: got v64=%b imm64=%h tgt64=%h vn=%b irn=%b", s64_ov, s64_imm, s64_tgt, n32_ov, n32_ir);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_random();
      logic [6:0]  ops[10];
      logic [31:0] r;
      int          idx;
      ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
      for (int i = 0; i < 3000; i++) begin
         r   = $urandom();
         idx = $urandom_range(0, 10);
         in_inst   = {r[31:7], (idx == 10) ? r[6:0] : ops[idx]};
         in_pc     = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(0, 4095)))
                                                 : {$urandom(), $urandom()};
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 31) == 0);
         cyc();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_inst   = 32'h0;
      in_pc     = 64'h0;
      test_reset();
      test_formats();
      test_skid_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) from a 32-bit instruction and sign-extends to XLEN. Also computes the PC-relative target. Sits between fetch and the register-read/execute stage behind a valid/ready handshake, with an optional skid buffer so backpressure never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width of the immediate and target (32 or 64)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single pipeline register with combinational in_ready

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline kill
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept an instruction
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded result valid
out_ready  in  1  downstream accepts result
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5
out_target  out  XLEN  computed target address
out_illegal  out  1  opcode not in the supported set

Behaviour:
- Opcode map, inst[6:0]:
  - 0000011, 0010011, 1100111: I; imm = sext(inst[31:20]).
  - 0100011: S; imm = sext({inst[31:25], inst[11:7]}).
  - 1100011: B; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111, 0010111: U; imm = sext({inst[31:12], 12'b0}) to XLEN.
  - 1101111: J; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0110011: R; imm = 0.
  - Anything else: fmt = R, imm = 0, out_illegal = 1.
- Sign extension always replicates inst[31] up to bit XLEN-1.
- out_target:
  - B, J, AUIPC: in_pc + imm.
  - All others: in_pc + 4.
  - Addition is modulo 2^XLEN; wrap-around is silent.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle from input transfer to out_valid. Throughput is 1 per cycle when out_ready = 1.
- Output stability: while out_valid && !out_ready, out_imm, out_fmt, out_target and out_illegal hold stable.
- SKID = 1:
  - in_ready = !skid_valid, registered.
  - On a stall, the instruction accepted in the same cycle goes into the skid entry.
  - The skid entry drains to the output register on the next output transfer.
  - Order is preserved.
- SKID = 0: in_ready = !out_valid || out_ready.
- flush:
  - In the flush cycle, in_ready is forced to 0 and no input transfer occurs.
  - The next edge clears out_valid and skid_valid.
  - Data registers are don't-care after flush.
- Simultaneous output transfer and input transfer: the output register reloads from skid (if valid) or from input; no bubble.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid = 0, skid_valid = 0, out_imm = 0, out_target = 0, out_fmt = 0, out_illegal = 0.
  - in_ready = 1 during and after reset (both SKID settings).
- Data registers have no enable other than load; no X may propagate to outputs after reset.

Decomposition:
- Package imm_pkg:
  - opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG).
  - fmt_e enum (3-bit).
  - Packed struct imm_res_t {imm, fmt, target, illegal}, parametrised by XLEN via the sub-module.
- Sub-module imm_decode: purely combinational, maps {inst, pc} to imm_res_t. imm_gen_pipe instantiates it once on the input path and owns all registers and handshake.

Test Plan:
1. XLEN=32, in_inst=0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
2. in_inst=0xFE000EE3 (beq x0,x0,-4), in_pc=0x100 -> out_imm=0xFFFFFFFC, out_fmt=3, out_target=0x000000FC.
3. in_inst=0x001000EF (jal x1,+2048), in_pc=0xFFFFF800 -> out_imm=0x800, out_fmt=5, out_target=0x00000000 (wrap). In_inst=0x123450B7 -> out_imm=0x12345000, out_fmt=4.
4. XLEN=64, in_inst=0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000.
5. SKID=1, stream A,B,C with out_ready=0 for 3 cycles:
   - A is held on the output; B sits in skid; in_ready=0; C is not accepted.
   - Raise out_ready -> A, B, C emerge in order, none lost or duplicated.
   - Repeat with SKID=0.
6. in_inst=0x0000007F -> out_illegal=1, out_imm=0.
   - Assert flush while stalled with a full skid -> next cycle out_valid=0, in_ready=1.
   - Assert rst_n=0 mid-stream -> outputs clear immediately.
